serial_mag_compare_ctrl: RTL
============================

// Module: serial_mag_compare_ctrl
// PURPOSE
//   Sequencer for the 4-bit cascadable magnitude-comparator slice (lt/eq/gt).
//   Compares two WIDTH-bit words by streaming nibbles through one comparator
//   slice, most significant nibble first, and stops early on the first
//   nibble that differs. Valid/ready request channel in, valid/ready result
//   channel out. Lets a single comparator slice serve wide-operand compares.
// PARAMETERS
//   WIDTH   16   operand width in bits; must be a multiple of 4 and >= 4
//   NNIB    WIDTH/4  number of nibbles (derived localparam, not overridable)
// PORTS
//   clk        in   1      clock; all state updates on the rising edge
//   rst_n      in   1      asynchronous active-low reset
//   flush      in   1      synchronous abort; forces IDLE and drops any result
//   req_valid  in   1      operand pair offered
//   req_ready  out  1      controller can accept an operand pair
//   req_a      in   WIDTH  operand A (unsigned)
//   req_b      in   WIDTH  operand B (unsigned)
//   res_valid  out  1      result available
//   res_ready  in   1      consumer accepts the result
//   res_lt     out  1      A < B
//   res_eq     out  1      A == B
//   res_gt     out  1      A > B
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous): state=IDLE, req_ready=0 while rst_n=0 and
//     1 from the first clock edge after release; res_valid, res_lt, res_eq,
//     res_gt = 0; shift registers and nibble counter = 0.
//   FSM states are IDLE, RUN and DONE.
//   IDLE: req_ready=1. On req_valid&&req_ready, load shA<=req_a and shB<=req_b,
//     set cnt<=NNIB-1, go to RUN. req_a/req_b are sampled only on that edge.
//   RUN: req_ready=0. The comparator slice sees shA[WIDTH-1 -: 4] and
//     shB[WIDTH-1 -: 4]. Its cascade inputs are tied to "equal".
//     - Nibble A > nibble B: res_gt<=1, go to DONE.
//     - Nibble A < nibble B: res_lt<=1, go to DONE.
//     - Nibbles equal and cnt==0: res_eq<=1, go to DONE.
//     - Nibbles equal and cnt!=0: shift shA and shB left by 4, cnt<=cnt-1,
//       stay in RUN.
//   DONE: res_valid=1. res_lt/eq/gt are one-hot and hold stable until the
//     handshake. On res_valid&&res_ready, clear res_*, go to IDLE.
//     req_ready=0 in DONE, so there is one bubble cycle between accepting a
//     result and accepting the next request.
//   Latency from the accept edge to res_valid=1: k cycles, where k is the
//     1-based index of the first differing nibble counted from the MSB.
//     Equal operands take NNIB cycles. Minimum 1, maximum NNIB.
//   Throughput: at most one compare per (k + 1) cycles, plus any res_ready
//     stall.
//   flush=1 in any state: next edge goes to IDLE; res_valid and res_* <= 0;
//     an in-flight compare is discarded. flush has priority over the request
//     accept and the result handshake in the same cycle.
//   Reset asserted during RUN or DONE: immediate return to reset values;
//     no result is produced.
//   req_valid held high in RUN or DONE: ignored, not queued.
//   res_ready high while res_valid=0: no effect.
//   res_lt|res_eq|res_gt = 0 whenever res_valid=0.
//   cnt width: $clog2(NNIB) bits, minimum 1. No wrap: cnt==0 always exits RUN.
// TESTING (WIDTH=16, NNIB=4)
//   1. A=16'h1234, B=16'h1234 accepted at edge 0 -> res_valid at edge 4,
//      res_eq=1, res_lt=0, res_gt=0.
//   2. A=16'h9000, B=16'h8FFF -> res_valid 1 cycle after accept, res_gt=1.
//      A=16'h00A0, B=16'h00B0 -> res_valid after 3 cycles, res_lt=1.
//   3. Result back-pressure: res_ready=0 for 5 cycles -> res_valid and res_*
//      hold stable, req_ready=0. res_ready=1 -> IDLE on the next edge and
//      req_ready=1 one cycle later.
//   4. flush pulsed in the 2nd RUN cycle of A=16'h0000, B=16'h0001 -> IDLE,
//      no res_valid. A following compare of A=16'h0005, B=16'h0003 gives
//      res_gt=1 after 4 cycles.
//   5. rst_n dropped mid-RUN, asynchronously -> all outputs 0 with no clock
//      edge. After release, req_ready=1 on the first edge.
//   6. Random sweep of 10k pairs against a (A<B, A==B, A>B) reference model
//      with random req_valid/res_ready gaps -> no mismatches, one-hot result,
//      latency equals the first differing nibble index.

Source files
------------

// File: rtl/serial_mag_compare_ctrl_if.sv
// Request/result channel bundle for the serial magnitude-compare sequencer.
// The master side offers operand pairs and consumes results.
interface serial_mag_compare_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             res_valid;
  logic             res_ready;
  logic             res_lt;
  logic             res_eq;
  logic             res_gt;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_lt, res_eq, res_gt
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_lt, res_eq, res_gt
  );
endinterface

// File: rtl/serial_mag_compare_ctrl.sv
// Streams WIDTH-bit operands MS nibble first through one 4-bit magnitude
// comparator slice, stopping on the first differing nibble.
//
// state | meaning
// IDLE  | ready for an operand pair (after first post-reset edge)
// RUN   | comparing the top nibble of the shift registers
// DONE  | one-hot result presented until consumed
module serial_mag_compare_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  input logic                     flush,
  serial_mag_compare_ctrl_if.slave bus
);
  localparam int NNIB = WIDTH / 4;
  localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b, sh_a_nxt, sh_b_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             lt_q, eq_q, gt_q;
  logic             lt_nxt, eq_nxt, gt_nxt;
  logic             armed;
  logic             req_ready;

  // Comparator slice with cascade inputs tied to "equal"
  localparam logic CASC_LT = 1'b0;
  localparam logic CASC_EQ = 1'b1;
  localparam logic CASC_GT = 1'b0;

  logic [3:0] nib_a, nib_b;
  logic       slice_lt, slice_eq, slice_gt;

  assign nib_a    = sh_a[WIDTH-1 -: 4];
  assign nib_b    = sh_b[WIDTH-1 -: 4];
  assign slice_gt = (nib_a > nib_b) | ((nib_a == nib_b) & CASC_GT);
  assign slice_lt = (nib_a < nib_b) | ((nib_a == nib_b) & CASC_LT);
  assign slice_eq = (nib_a == nib_b) & CASC_EQ;

  // armed keeps req_ready low until the first edge after reset release
  assign req_ready     = armed && (state == IDLE);
  assign bus.req_ready = req_ready;
  assign bus.res_valid = (state == DONE);
  assign bus.res_lt    = lt_q;
  assign bus.res_eq    = eq_q;
  assign bus.res_gt    = gt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      cnt   <= '0;
      lt_q  <= 1'b0;
      eq_q  <= 1'b0;
      gt_q  <= 1'b0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      sh_a  <= sh_a_nxt;
      sh_b  <= sh_b_nxt;
      cnt   <= cnt_nxt;
      lt_q  <= lt_nxt;
      eq_q  <= eq_nxt;
      gt_q  <= gt_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    sh_a_nxt  = sh_a;
    sh_b_nxt  = sh_b;
    cnt_nxt   = cnt;
    lt_nxt    = lt_q;
    eq_nxt    = eq_q;
    gt_nxt    = gt_q;

    if (flush) begin
      state_nxt = IDLE;
      lt_nxt    = 1'b0;
      eq_nxt    = 1'b0;
      gt_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && req_ready) begin
            sh_a_nxt  = bus.req_a;
            sh_b_nxt  = bus.req_b;
            cnt_nxt   = CW'(NNIB - 1);
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (slice_gt) begin
            gt_nxt    = 1'b1;
            state_nxt = DONE;
          end else if (slice_lt) begin
            lt_nxt    = 1'b1;
            state_nxt = DONE;
          end else if (slice_eq && (cnt == '0)) begin
            eq_nxt    = 1'b1;
            state_nxt = DONE;
          end else begin
            sh_a_nxt = sh_a << 4;
            sh_b_nxt = sh_b << 4;
            cnt_nxt  = cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            lt_nxt    = 1'b0;
            eq_nxt    = 1'b0;
            gt_nxt    = 1'b0;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
endmodule
